// File: rtl/ch4_sequencer_if.sv
// Bus between register decode / frame sequencer and the channel 4 control sequencer.
interface ch4_sequencer_if;
   logic       apu_en;
   logic       tick_512;
   logic       wr_ff20;
   logic       wr_ff21;
   logic       wr_ff23;
   logic [7:0] wdata;
   logic       ch4_restart;
   logic       ch4_active;
   logic       nch4_active;
   logic       nch4_amp_en;
   logic       ch4_len_tick;
   logic       ch4_eg_tick;
   logic       ff23_d6;

   modport master (
      output apu_en, tick_512, wr_ff20, wr_ff21, wr_ff23, wdata,
      input  ch4_restart, ch4_active, nch4_active, nch4_amp_en,
             ch4_len_tick, ch4_eg_tick, ff23_d6
   );

   modport slave (
      input  apu_en, tick_512, wr_ff20, wr_ff21, wr_ff23, wdata,
      output ch4_restart, ch4_active, nch4_active, nch4_amp_en,
             ch4_len_tick, ch4_eg_tick, ff23_d6
   );
endinterface

// File: rtl/ch4_sequencer.sv
// Noise channel 4 length/trigger/restart sequencer; strobes are combinational, state registered.
// Optional CH4_LEN_EXTRA_CLOCK_EN: extra length clock when len_en rises on an odd frame step.
module ch4_sequencer #(
   parameter int RESTART_CYCLES = 2,
   parameter int LEN_BITS       = 6
) (
   input  logic           nphi,
   input  logic           napu_reset,
   ch4_sequencer_if.slave bus
);
   localparam int RCW = $clog2(RESTART_CYCLES + 1);
   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_RESTART = 1'b1;
   localparam logic [LEN_BITS:0] LEN_MAX = {1'b1, {LEN_BITS{1'b0}}};
   localparam logic [LEN_BITS:0] LEN_ONE = (LEN_BITS + 1)'(1);
   localparam logic [RCW-1:0]    R_LOAD  = RCW'(RESTART_CYCLES);
   localparam logic [RCW-1:0]    R_ONE   = RCW'(1);

   logic [2:0]          fs, fs_nx;
   logic [LEN_BITS:0]   len_cnt, len_nx;
   logic                len_en, len_en_nx;
   logic                dac_en, dac_en_nx;
   logic                active, act_nx;
   logic [0:0]          state, state_nx;
   logic [RCW-1:0]      rcnt, rcnt_nx;
   logic                len_tick, eg_tick, trig;

   always_comb begin
      len_tick  = bus.apu_en & bus.tick_512 & ~fs[0];
      eg_tick   = bus.apu_en & bus.tick_512 & (fs == 3'd7);
      trig      = bus.wr_ff23 & bus.wdata[7];
      fs_nx     = bus.tick_512 ? fs + 3'd1 : fs;
      len_en_nx = bus.wr_ff23 ? bus.wdata[6] : len_en;
      dac_en_nx = bus.wr_ff21 ? |bus.wdata[7:3] : dac_en;
      len_nx    = len_cnt;
      act_nx    = active;
      state_nx  = state;
      rcnt_nx   = rcnt;

      if (trig)
         act_nx = dac_en_nx;

      if (bus.wr_ff20) begin
         len_nx = {1'b0, bus.wdata[LEN_BITS-1:0]};
      end else begin
`ifdef CH4_LEN_EXTRA_CLOCK_EN
         if (bus.wr_ff23 && bus.wdata[6] && !len_en && fs[0] && len_nx < LEN_MAX) begin
            len_nx = len_nx + LEN_ONE;
            if (len_nx == LEN_MAX && !trig)
               act_nx = 1'b0;
         end
`endif
         // Trigger reloads an expired counter before this cycle's length tick is applied.
         if (trig && len_nx == LEN_MAX)
            len_nx = '0;
         if (len_tick && len_en_nx && len_nx < LEN_MAX) begin
            len_nx = len_nx + LEN_ONE;
            if (len_nx == LEN_MAX)
               act_nx = 1'b0;
         end
      end

      if (!dac_en_nx)
         act_nx = 1'b0;

      if (trig) begin
         state_nx = S_RESTART;
         rcnt_nx  = R_LOAD;
      end else if (state == S_RESTART) begin
         rcnt_nx = rcnt - R_ONE;
         if (rcnt_nx == '0)
            state_nx = S_IDLE;
      end
   end

   always_ff @(posedge nphi or negedge napu_reset) begin
      if (!napu_reset) begin
         fs      <= '0;
         len_cnt <= '0;
         len_en  <= 1'b0;
         dac_en  <= 1'b0;
         active  <= 1'b0;
         state   <= S_IDLE;
         rcnt    <= '0;
      end else if (!bus.apu_en) begin
         fs      <= '0;
         len_cnt <= '0;
         len_en  <= 1'b0;
         dac_en  <= 1'b0;
         active  <= 1'b0;
         state   <= S_IDLE;
         rcnt    <= '0;
      end else begin
         fs      <= fs_nx;
         len_cnt <= len_nx;
         len_en  <= len_en_nx;
         dac_en  <= dac_en_nx;
         active  <= act_nx;
         state   <= state_nx;
         rcnt    <= rcnt_nx;
      end
   end

   assign bus.ch4_restart  = (state == S_RESTART);
   assign bus.ch4_active   = active;
   assign bus.nch4_active  = ~active;
   assign bus.nch4_amp_en  = ~dac_en;
   assign bus.ch4_len_tick = len_tick;
   assign bus.ch4_eg_tick  = eg_tick;
   assign bus.ff23_d6      = len_en;
endmodule

// File: tb/tb_ch4_sequencer.sv
// Directed vector bench for ch4_sequencer: per-cycle table plus multi-cycle count sequences.
module tb_ch4_sequencer;
   logic nphi = 1'b0;
   logic napu_reset = 1'b0;
   ch4_sequencer_if bif ();

   ch4_sequencer dut (
      .nphi       (nphi),
      .napu_reset (napu_reset),
      .bus        (bif)
   );

   always #5 nphi = ~nphi;

`ifdef CH4_LEN_EXTRA_CLOCK_EN
   localparam logic XACT = 1'b0;
`else
   localparam logic XACT = 1'b1;
`endif

   typedef struct {
      logic       apu, tick, w20, w21, w23;
      logic [7:0] d;
      logic       rs, act, namp, lt, et, d6;
   } vec_t;

   vec_t vt[$];
   int   nvec = 0;
   int   nerr = 0;

   task automatic add(input logic apu, tick, w20, w21, w23, input logic [7:0] d,
                      input logic rs, act, namp, lt, et, d6);
      vec_t v;
      v.apu = apu; v.tick = tick; v.w20 = w20; v.w21 = w21; v.w23 = w23; v.d = d;
      v.rs = rs; v.act = act; v.namp = namp; v.lt = lt; v.et = et; v.d6 = d6;
      vt.push_back(v);
   endtask

   task automatic set_in(input logic apu, tick, w20, w21, w23, input logic [7:0] d);
      bif.apu_en = apu; bif.tick_512 = tick;
      bif.wr_ff20 = w20; bif.wr_ff21 = w21; bif.wr_ff23 = w23; bif.wdata = d;
   endtask

   task automatic next_cycle();
      @(posedge nphi);
      #1;
   endtask

   task automatic chk_int(input string nm, input int got, input int want);
      nvec++;
      if (got != want) begin
         nerr++;
         $display("FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   logic [6:0] got_v, exp_v;
   int n;
   bit done;

   initial begin
      set_in(1, 0, 0, 0, 0, 8'h00);
      // apu tick w20 w21 w23 data     rs act namp lt et d6
      add(1,0,0,0,0,8'h00, 0,0,1,0,0,0);   // reset state
      add(1,0,0,1,0,8'hF0, 0,0,1,0,0,0);   // NR42 = F0
      add(1,0,0,0,1,8'h80, 0,0,0,0,0,0);   // trigger
      add(1,0,0,0,0,8'h00, 1,1,0,0,0,0);
      add(1,0,0,0,0,8'h00, 1,1,0,0,0,0);
      add(1,0,0,0,0,8'h00, 0,1,0,0,0,0);   // pulse was 2 clocks
      add(1,0,1,0,0,8'h3E, 0,1,0,0,0,0);   // NR41 = 3E
      add(1,0,0,0,1,8'hC0, 0,1,0,0,0,0);   // trigger + len_en
      add(1,1,0,0,0,8'h00, 1,1,0,1,0,1);   // fs0 tick -> 63
      add(1,1,0,0,0,8'h00, 1,1,0,0,0,1);   // fs1
      add(1,1,0,0,0,8'h00, 0,1,0,1,0,1);   // fs2 tick -> 64
      add(1,1,0,0,0,8'h00, 0,0,0,0,0,1);   // expired
      add(1,1,0,0,0,8'h00, 0,0,0,1,0,1);   // fs4 tick, counter holds
      add(1,0,0,0,0,8'h00, 0,0,0,0,0,1);
      add(1,1,0,0,0,8'h00, 0,0,0,0,0,1);   // fs5
      add(1,1,0,0,1,8'hC0, 0,0,0,1,0,1);   // fs6 tick + trigger: reload then +1
      add(1,0,0,0,0,8'h00, 1,1,0,0,0,1);
      add(1,0,0,0,0,8'h00, 1,1,0,0,0,1);
      add(1,0,0,0,0,8'h00, 0,1,0,0,0,1);
      add(1,0,0,1,0,8'h07, 0,1,0,0,0,1);   // DAC off
      add(1,0,0,0,0,8'h00, 0,0,1,0,0,1);
      add(1,0,0,0,1,8'h80, 0,0,1,0,0,1);   // trigger with DAC off
      add(1,0,0,0,0,8'h00, 1,0,1,0,0,0);
      add(1,0,0,0,0,8'h00, 1,0,1,0,0,0);
      add(1,0,0,0,0,8'h00, 0,0,1,0,0,0);
      add(1,0,0,1,0,8'hF0, 0,0,1,0,0,0);   // DAC on
      add(1,0,0,0,1,8'h80, 0,0,0,0,0,0);   // trigger
      add(1,0,0,0,1,8'h80, 1,1,0,0,0,0);   // retrigger one clock in
      add(1,0,0,0,0,8'h00, 1,1,0,0,0,0);
      add(1,0,0,0,0,8'h00, 1,1,0,0,0,0);
      add(1,0,0,0,0,8'h00, 0,1,0,0,0,0);   // pulse was 3 clocks
      add(1,0,0,0,1,8'h40, 0,1,0,0,0,0);   // len_en only
      add(1,1,0,0,0,8'h00, 0,1,0,0,1,1);   // fs7: envelope strobe
      add(1,1,1,0,0,8'hFF, 0,1,0,1,0,1);   // fs0: NR41 write beats tick -> 63
      add(1,0,0,0,0,8'h00, 0,1,0,0,0,1);
      add(1,1,0,0,0,8'h00, 0,1,0,0,0,1);   // fs1
      add(1,1,0,0,0,8'h00, 0,1,0,1,0,1);   // fs2 tick -> 64
      add(1,0,0,0,0,8'h00, 0,0,0,0,0,1);
      add(1,0,0,0,1,8'h80, 0,0,0,0,0,1);   // trigger
      add(1,0,0,0,0,8'h00, 1,1,0,0,0,0);
      add(0,0,0,0,0,8'h00, 1,1,0,0,0,0);   // apu_en drops mid-pulse
      add(0,1,1,1,1,8'hC0, 0,0,1,0,0,0);   // cleared, writes and ticks ignored
      add(1,0,0,0,0,8'h00, 0,0,1,0,0,0);
      for (int i = 0; i < 8; i++)
         add(1,1,0,0,0,8'h00, 0,0,1,(i % 2 == 0),(i == 7),0);
      add(1,1,0,0,0,8'h00, 0,0,1,1,0,0);   // fs wrapped to 0
      add(1,0,0,1,0,8'hF0, 0,0,1,0,0,0);
      add(1,0,1,0,0,8'h3F, 0,0,0,0,0,0);   // len 63
      add(1,0,0,0,1,8'h80, 0,0,0,0,0,0);   // trigger, len_en off
      add(1,0,0,0,0,8'h00, 1,1,0,0,0,0);
      add(1,0,0,0,0,8'h00, 1,1,0,0,0,0);
      add(1,0,0,0,1,8'h40, 0,1,0,0,0,0);   // len_en 0->1 on odd fs
      add(1,0,0,0,0,8'h00, 0,XACT,0,0,0,1);
      add(1,0,0,0,0,8'h00, 0,XACT,0,0,0,1);

      repeat (3) @(posedge nphi);
      #1 napu_reset = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         set_in(vt[i].apu, vt[i].tick, vt[i].w20, vt[i].w21, vt[i].w23, vt[i].d);
         @(negedge nphi);
         got_v = {bif.ch4_restart, bif.ch4_active, bif.nch4_active, bif.nch4_amp_en,
                  bif.ch4_len_tick, bif.ch4_eg_tick, bif.ff23_d6};
         exp_v = {vt[i].rs, vt[i].act, ~vt[i].act, vt[i].namp,
                  vt[i].lt, vt[i].et, vt[i].d6};
         nvec++;
         if (got_v !== exp_v) begin
            nerr++;
            $display("FAIL vec[%0d] {rs,act,nact,namp,lt,et,d6}: got %b, want %b",
                     i, got_v, exp_v);
         end
         next_cycle();
      end

      // Full length run from 0: active must survive exactly 64 length ticks.
      set_in(1, 0, 1, 0, 0, 8'h00);
      next_cycle();
      set_in(1, 0, 0, 0, 1, 8'hC0);
      next_cycle();
      n = 0;
      done = 0;
      for (int c = 0; c < 400 && !done; c++) begin
         set_in(1, 1, 0, 0, 0, 8'h00);
         @(negedge nphi);
         if (!bif.ch4_active) done = 1;
         else if (bif.ch4_len_tick) n++;
         next_cycle();
      end
      chk_int("len_run_finished", int'(done), 1);
      chk_int("len_ticks_to_expire", n, 64);

      // Single trigger from IDLE: restart width.
      set_in(1, 0, 0, 0, 1, 8'h80);
      next_cycle();
      set_in(1, 0, 0, 0, 0, 8'h00);
      n = 0;
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge nphi);
         if (bif.ch4_restart) n++;
         else done = 1;
         next_cycle();
      end
      chk_int("restart_fell", int'(done), 1);
      chk_int("restart_width", n, 2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
